b1_linebuf: RTL and testbench
=============================

B1_LINEBUF -- requirements
Module: b1_linebuf

Interface
REQ-001 SHALL have port: CLK_24M  in  1  master clock; all state updates on its rising edge.
REQ-002 SHALL have port: RESETP  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: LD1_N  in  1  active-low X-address load for pair A (RAMs 0,1).
REQ-004 SHALL have port: LD2_N  in  1  active-low X-address load for pair B (RAMs 2,3).
REQ-005 SHALL have port: XPOS  in  8  load value (sprite X[8:1]).
REQ-006 SHALL have port: CK  in  4  per-RAM access/advance strobe; RAM order: 0 odd A, 1 even A, 2 odd B, 3 even B.
REQ-007 SHALL have port: WE_N  in  4  per-RAM active-low write enable; same order as CK.
REQ-008 SHALL have port: GAD  in  4  even pixel colour index.
REQ-009 SHALL have port: GBD  in  4  odd pixel colour index.
REQ-010 SHALL have port: PAL  in  8  palette number written with the pixel.
REQ-011 SHALL have port: SS1  in  1  selects pair A for readout.
REQ-012 SHALL have port: SS2  in  1  selects pair B for readout.
REQ-013 SHALL have port: PIX_EVEN  out  12  {PAL,index} read from the even RAM of the readout pair.
REQ-014 SHALL have port: PIX_ODD  out  12  {PAL,index} read from the odd RAM of the readout pair.

Function
REQ-015 SHALL contain four 256x12 RAMs, each with its own 8-bit address counter.
REQ-016 LD1_N=0 SHALL load XPOS into counters 0 and 1; LD2_N=0 SHALL load XPOS into counters 2 and 3.
REQ-017 On the same RAM, load SHALL take priority over CK; that cycle performs no access and no increment.
REQ-018 Readout pair: SS1=1 selects A; SS1=0 and SS2=1 selects B; both 0 means no readout pair.
REQ-019 CK[n]=1 on a non-readout RAM with WE_N[n]=0 SHALL write {PAL,GAD} (even RAMs) or {PAL,GBD} (odd RAMs) at the counter address, then increment the counter.
REQ-020 Opacity: a write whose colour index is 0 SHALL be suppressed, but the counter SHALL still increment.
REQ-021 CK[n]=1 on a non-readout RAM with WE_N[n]=1 SHALL only increment the counter.
REQ-022 CK[n]=1 on a readout-pair RAM SHALL register the addressed word into PIX_EVEN or PIX_ODD one cycle later, then increment the counter; WE_N SHALL be ignored.
REQ-023 PIX_EVEN and PIX_ODD SHALL hold their values between reads.
REQ-024 Counters SHALL wrap from 255 to 0 without flag or stall.
REQ-025 CK strobes on different RAMs SHALL act independently within the same cycle.

Reset
REQ-026 While RESETP=1: all counters =0, PIX_EVEN=PIX_ODD=12'h000, no RAM access.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 Assertion during an access SHALL abort that access; deassertion SHALL take effect at the next CLK_24M edge.

Configuration
REQ-029 Macro B1_LB_CLEAR_EN defined: every readout access (REQ-022) SHALL also write 12'h000 to the same address in the same cycle (read-before-clear).
REQ-030 Macro B1_LB_CLEAR_EN undefined: readout SHALL be non-destructive; software clears via WE_N writes (write of 12'h000 exempt from REQ-020 only when the macro is defined — otherwise index 0 is never written).

Structure
REQ-031 Shared package b1_pkg SHALL hold LB_DEPTH=256, LB_AW=8, LB_DW=12, TRANSPARENT=4'h0, and the RAM index constants.
REQ-032 A sub-module lb_ram (256x12 synchronous single-port RAM, registered read) SHALL be instantiated four times.

Verification
REQ-033 Write path: LD1_N pulse with XPOS=8'h10, three CK[1] with WE_N[1]=0 and GAD=5,0,7, PAL=8'h22, SS2=1; then SS1=1, LD1_N with XPOS=8'h10, three CK[1] -> PIX_EVEN = 12'h225, unchanged location (pre-content), 12'h227.
REQ-034 Wrap: load XPOS=8'hFF, two writes on RAM 2 with SS1=1 -> data lands at addresses 255 and 0.
REQ-035 Load versus CK: LD2_N=0 and CK[3]=1 in the same cycle -> counter = XPOS, no write occurs.
REQ-036 Clear: with B1_LB_CLEAR_EN defined, read address 8'h10 twice -> first read returns the written value, second returns 12'h000; without the macro, both reads return the written value.
REQ-037 Reset: RESETP pulsed mid-sequence -> outputs 0, counters 0, RAM data written before reset still readable afterwards.

Source files
------------

// File: rtl/b1_linebuf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : b1_pkg                                                   |
// | Desc    : Shared constants, readout-pair select type and helpers   |
// |           for the B1 sprite line buffer.                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package b1_pkg;

   localparam int LB_DEPTH = 256;
   localparam int LB_AW    = 8;
   localparam int LB_DW    = 12;
   localparam int NUM_RAMS = 4;

   localparam logic [3:0] TRANSPARENT = 4'h0;

   localparam int RAM_ODD_A  = 0;
   localparam int RAM_EVEN_A = 1;
   localparam int RAM_ODD_B  = 2;
   localparam int RAM_EVEN_B = 3;

   typedef enum logic [1:0] {
      RD_NONE   = 2'd0,
      RD_PAIR_A = 2'd1,
      RD_PAIR_B = 2'd2
   } rd_sel_e;

   function automatic logic is_even_ram(input int idx);
      return (idx == RAM_EVEN_A) || (idx == RAM_EVEN_B);
   endfunction

   function automatic logic is_pair_a(input int idx);
      return (idx == RAM_ODD_A) || (idx == RAM_EVEN_A);
   endfunction

   function automatic logic ram_in_readout(input rd_sel_e sel, input int idx);
      return is_pair_a(idx) ? (sel == RD_PAIR_A) : (sel == RD_PAIR_B);
   endfunction

endpackage
`default_nettype wire

// File: rtl/b1_linebuf_lb_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lb_ram                                                   |
// | Desc    : 256x12 synchronous single-port RAM, registered read,     |
// |           read-before-write when read and write share a cycle.     |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module lb_ram
   import b1_pkg::*;
(
   input  logic             CLK_24M,
   input  logic             i_re,
   input  logic             i_we,
   input  logic [LB_AW-1:0] i_addr,
   input  logic [LB_DW-1:0] i_wdata,
   output logic [LB_DW-1:0] o_rdata
);

   logic [LB_DW-1:0] r_mem [LB_DEPTH];
   logic [LB_DW-1:0] r_rdata;

   // Contents deliberately have no reset; the read register holds between reads.
   always_ff @(posedge CLK_24M) begin
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/b1_linebuf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : b1_linebuf                                               |
// | Desc    : Four-RAM sprite line buffer (two odd/even pairs) with    |
// |           per-RAM X counters, opaque writes and pair readout.      |
// |           Option macro B1_LB_CLEAR_EN: readout clears the word.    |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module b1_linebuf
   import b1_pkg::*;
(
   input  logic        CLK_24M,
   input  logic        RESETP,
   input  logic        LD1_N,
   input  logic        LD2_N,
   input  logic [7:0]  XPOS,
   input  logic [3:0]  CK,
   input  logic [3:0]  WE_N,
   input  logic [3:0]  GAD,
   input  logic [3:0]  GBD,
   input  logic [7:0]  PAL,
   input  logic        SS1,
   input  logic        SS2,
   output logic [11:0] PIX_EVEN,
   output logic [11:0] PIX_ODD
);

   rd_sel_e          w_rd_sel;
   logic [3:0]       w_pend;
   logic [LB_DW-1:0] w_q [NUM_RAMS];
   logic [LB_DW-1:0] r_pix_even;
   logic [LB_DW-1:0] r_pix_odd;

   always_comb begin
      w_rd_sel = RD_NONE;
      if (SS1) begin
         w_rd_sel = RD_PAIR_A;
      end else if (SS2) begin
         w_rd_sel = RD_PAIR_B;
      end
   end

   generate
      for (genvar g = 0; g < NUM_RAMS; g++) begin : g_ram
         localparam logic c_even   = is_even_ram(g);
         localparam logic c_pair_a = is_pair_a(g);

         logic [LB_AW-1:0] r_cnt;
         logic             r_rd_pend;
         logic [3:0]       w_idx;
         logic             w_ld;
         logic             w_acc;
         logic             w_rd;
         logic             w_wr;
         logic [LB_DW-1:0] w_wdata;
         logic [LB_DW-1:0] w_q_loc;

         assign w_ld  = c_pair_a ? ~LD1_N : ~LD2_N;
         // A load steals the cycle; reset blocks any access.
         assign w_acc = CK[g] & ~w_ld & ~RESETP;
         assign w_rd  = w_acc & ram_in_readout(w_rd_sel, g);
         assign w_idx = c_even ? GAD : GBD;

`ifdef B1_LB_CLEAR_EN
         assign w_wr    = w_rd | (w_acc & ~WE_N[g] & (w_idx != TRANSPARENT));
         assign w_wdata = w_rd ? '0 : {PAL, w_idx};
`else
         assign w_wr    = w_acc & ~w_rd & ~WE_N[g] & (w_idx != TRANSPARENT);
         assign w_wdata = {PAL, w_idx};
`endif

         always_ff @(posedge CLK_24M or posedge RESETP) begin
            if (RESETP) begin
               r_cnt     <= '0;
               r_rd_pend <= 1'b0;
            end else begin
               r_rd_pend <= w_rd;
               if (w_ld) begin
                  r_cnt <= XPOS;
               end else if (CK[g]) begin
                  r_cnt <= r_cnt + LB_AW'(1);
               end
            end
         end

         lb_ram u_ram (
            .CLK_24M (CLK_24M),
            .i_re    (w_rd),
            .i_we    (w_wr),
            .i_addr  (r_cnt),
            .i_wdata (w_wdata),
            .o_rdata (w_q_loc)
         );

         assign w_pend[g] = r_rd_pend;
         assign w_q[g]    = w_q_loc;
      end
   endgenerate

   // Only one pair is ever in readout, so at most one pending flag per side is set.
   always_ff @(posedge CLK_24M or posedge RESETP) begin
      if (RESETP) begin
         r_pix_even <= '0;
         r_pix_odd  <= '0;
      end else begin
         if (w_pend[RAM_EVEN_A]) begin
            r_pix_even <= w_q[RAM_EVEN_A];
         end else if (w_pend[RAM_EVEN_B]) begin
            r_pix_even <= w_q[RAM_EVEN_B];
         end
         if (w_pend[RAM_ODD_A]) begin
            r_pix_odd <= w_q[RAM_ODD_A];
         end else if (w_pend[RAM_ODD_B]) begin
            r_pix_odd <= w_q[RAM_ODD_B];
         end
      end
   end

   assign PIX_EVEN = r_pix_even;
   assign PIX_ODD  = r_pix_odd;

endmodule
`default_nettype wire

// File: tb/tb_b1_linebuf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_b1_linebuf                                            |
// | Desc    : Scoreboard bench for b1_linebuf with a behavioural model.|
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_b1_linebuf;
   import b1_pkg::*;

   logic        CLK_24M = 1'b0;
   logic        RESETP  = 1'b1;
   logic        LD1_N   = 1'b1;
   logic        LD2_N   = 1'b1;
   logic [7:0]  XPOS    = '0;
   logic [3:0]  CK      = '0;
   logic [3:0]  WE_N    = 4'hF;
   logic [3:0]  GAD     = '0;
   logic [3:0]  GBD     = '0;
   logic [7:0]  PAL     = '0;
   logic        SS1     = 1'b0;
   logic        SS2     = 1'b0;
   logic [11:0] PIX_EVEN;
   logic [11:0] PIX_ODD;

   always #5 CLK_24M = ~CLK_24M;

   b1_linebuf dut (
      .CLK_24M  (CLK_24M),
      .RESETP   (RESETP),
      .LD1_N    (LD1_N),
      .LD2_N    (LD2_N),
      .XPOS     (XPOS),
      .CK       (CK),
      .WE_N     (WE_N),
      .GAD      (GAD),
      .GBD      (GBD),
      .PAL      (PAL),
      .SS1      (SS1),
      .SS2      (SS2),
      .PIX_EVEN (PIX_EVEN),
      .PIX_ODD  (PIX_ODD)
   );

   typedef struct {
      int          due;
      bit          is_rst;
      bit          even;
      logic [11:0] val;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [11:0] m_mem [4][256];
   int          m_cnt [4];
   int          edge_n   = 0;
   int          errors   = 0;
   int          checks   = 0;
   logic [11:0] exp_even = '0;
   logic [11:0] exp_odd  = '0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_n);
      end
   endtask

   // Reference model: line buffer as four arrays plus integer X positions.
   function automatic void model_edge();
      bit          sel_a;
      bit          sel_b;
      bit          pa;
      bit          ev;
      bit          ld;
      logic [3:0]  idx;
      exp_t        e;
      if (RESETP) begin
         for (int n = 0; n < 4; n++) m_cnt[n] = 0;
         return;
      end
      sel_a = SS1;
      sel_b = !SS1 && SS2;
      for (int n = 0; n < 4; n++) begin
         pa  = (n < 2);
         ev  = (n % 2 == 1);
         ld  = pa ? !LD1_N : !LD2_N;
         idx = ev ? GAD : GBD;
         if (ld) begin
            m_cnt[n] = int'(XPOS);
         end else if (CK[n]) begin
            if (pa ? sel_a : sel_b) begin
               e.due    = edge_n + 1;
               e.is_rst = 1'b0;
               e.even   = ev;
               e.val    = m_mem[n][m_cnt[n]];
               sbq.push_back(e);
`ifdef B1_LB_CLEAR_EN
               m_mem[n][m_cnt[n]] = 12'h000;
`endif
            end else if (!WE_N[n] && idx != 4'h0) begin
               m_mem[n][m_cnt[n]] = {PAL, idx};
            end
            m_cnt[n] = (m_cnt[n] + 1) % 256;
         end
      end
   endfunction

   task automatic step();
      @(posedge CLK_24M);
      edge_n++;
      model_edge();
      #1;
   endtask

   // Asynchronous assertion mid-cycle, with strobes active to show no access happens.
   task automatic reset_pulse(input int edges);
      exp_t e;
      #2;
      RESETP = 1'b1;
      sbq.delete();
      e.due    = edge_n;
      e.is_rst = 1'b1;
      e.even   = 1'b0;
      e.val    = '0;
      sbq.push_back(e);
      CK = 4'hF; WE_N = 4'h0; GAD = 4'h1; GBD = 4'h1; PAL = 8'hEE;
      repeat (edges) step();
      RESETP = 1'b0;
      CK = 4'h0; WE_N = 4'hF;
   endtask

   always @(negedge CLK_24M) begin
      while (sbq.size() > 0 && sbq[0].due <= edge_n) begin
         mon_e = sbq.pop_front();
         if (mon_e.is_rst) begin
            exp_even = '0;
            exp_odd  = '0;
         end else if (mon_e.even) begin
            exp_even = mon_e.val;
         end else begin
            exp_odd = mon_e.val;
         end
      end
      check("mon_pix_even", PIX_EVEN, exp_even);
      check("mon_pix_odd",  PIX_ODD,  exp_odd);
   end

   initial begin
      repeat (3) step();
      check("reset_even", PIX_EVEN, 12'h000);
      check("reset_odd",  PIX_ODD,  12'h000);
      RESETP = 1'b0;

      // Fill every RAM with known opaque data, no readout pair.
      LD1_N = 1'b0; LD2_N = 1'b0; XPOS = 8'h00; step();
      LD1_N = 1'b1; LD2_N = 1'b1;
      CK = 4'hF; WE_N = 4'h0;
      for (int i = 0; i < 256; i++) begin
         GAD = 4'($urandom_range(1, 15));
         GBD = 4'($urandom_range(1, 15));
         PAL = 8'($urandom);
         step();
      end
      CK = 4'h0; WE_N = 4'hF;

      // Write path with a transparent middle pixel, then read back on pair A.
      SS1 = 1'b0; SS2 = 1'b1;
      XPOS = 8'h10; LD1_N = 1'b0; step(); LD1_N = 1'b1;
      PAL = 8'h22; WE_N = 4'b1101; CK = 4'b0010;
      GAD = 4'd5; step();
      GAD = 4'd0; step();
      GAD = 4'd7; step();
      CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b1;
      LD1_N = 1'b0; step(); LD1_N = 1'b1;
      CK = 4'b0010; step(); CK = 4'h0; step();
      check("wr_first", PIX_EVEN, 12'h225);
      CK = 4'b0010; step(); CK = 4'h0; step();
      CK = 4'b0010; step(); CK = 4'h0; step();
      check("wr_third", PIX_EVEN, 12'h227);
      step();
      check("hold_even", PIX_EVEN, 12'h227);

      // Counter wrap on RAM 2.
      SS1 = 1'b1; SS2 = 1'b0;
      XPOS = 8'hFF; LD2_N = 1'b0; step(); LD2_N = 1'b1;
      CK = 4'b0100; WE_N = 4'b1011;
      GBD = 4'h9; PAL = 8'h33; step();
      GBD = 4'h4; PAL = 8'h44; step();
      CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b0; SS2 = 1'b1;
      LD2_N = 1'b0; step(); LD2_N = 1'b1;
      CK = 4'b0100; step(); CK = 4'h0; step();
      check("wrap_255", PIX_ODD, 12'h339);
      CK = 4'b0100; step(); CK = 4'h0; step();
      check("wrap_000", PIX_ODD, 12'h444);

      // Load beats CK on RAM 3: counter takes XPOS, nothing written.
      SS1 = 1'b1; SS2 = 1'b0;
      XPOS = 8'h40; LD2_N = 1'b0; CK = 4'b1000; WE_N = 4'b0111;
      GAD = 4'hA; PAL = 8'h55; step();
      LD2_N = 1'b1;
      GAD = 4'hB; PAL = 8'h56; step();
      CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b0; SS2 = 1'b1;
      XPOS = 8'h40; LD2_N = 1'b0; step(); LD2_N = 1'b1;
      CK = 4'b1000; step(); CK = 4'h0; step();
      check("ld_vs_ck", PIX_EVEN, 12'h56B);

      // Double read of one address.
      SS1 = 1'b0; SS2 = 1'b1;
      XPOS = 8'h10; LD1_N = 1'b0; step(); LD1_N = 1'b1;
      CK = 4'b0010; WE_N = 4'b1101; GAD = 4'hC; PAL = 8'h66; step();
      CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b1;
      LD1_N = 1'b0; step(); LD1_N = 1'b1;
      CK = 4'b0010; step(); CK = 4'h0; step();
      check("clr_read1", PIX_EVEN, 12'h66C);
      LD1_N = 1'b0; step(); LD1_N = 1'b1;
      CK = 4'b0010; step(); CK = 4'h0; step();
`ifdef B1_LB_CLEAR_EN
      check("clr_read2", PIX_EVEN, 12'h000);
`else
      check("clr_read2", PIX_EVEN, 12'h66C);
`endif

      // Randomised traffic against the model.
      for (int i = 0; i < 800; i++) begin
         LD1_N = ($urandom_range(0, 7) != 0);
         LD2_N = ($urandom_range(0, 7) != 0);
         XPOS  = 8'($urandom);
         CK    = 4'($urandom);
         WE_N  = 4'($urandom);
         GAD   = 4'($urandom);
         GBD   = 4'($urandom);
         PAL   = 8'($urandom);
         SS1   = 1'($urandom);
         SS2   = 1'($urandom);
         step();
      end
      LD1_N = 1'b1; LD2_N = 1'b1; CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b0; SS2 = 1'b0;
      step();

      // Reset mid-sequence: RAM data survives, counters restart at 0.
      XPOS = 8'h00; LD1_N = 1'b0; step(); LD1_N = 1'b1;
      CK = 4'b0011; WE_N = 4'b1100; GAD = 4'h3; GBD = 4'hE; PAL = 8'h77; step();
      CK = 4'h0; WE_N = 4'hF;
      SS1 = 1'b1;
      CK = 4'b0011; step(); CK = 4'h0; step();
      reset_pulse(2);
      check("rst_even", PIX_EVEN, 12'h000);
      check("rst_odd",  PIX_ODD,  12'h000);
      CK = 4'b0011; step(); CK = 4'h0; step();
      check("post_rst_even", PIX_EVEN, 12'h773);
      check("post_rst_odd",  PIX_ODD,  12'h77E);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
